// File: rtl/boot_loader.sv
// Image loader: holds the CPU in reset, streams a length/data/checksum image into RAM,
// then releases the CPU and passes its bus straight through to the RAM.
module boot_loader #(
    parameter logic [29:0] BASE_WADDR = 30'd0,
    parameter int unsigned MAX_WORDS  = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        load_req,
    output logic        cpu_reset,
    input  logic [29:0] cpu_bus_addr,
    input  logic [31:0] cpu_bus_data_w,
    input  logic [3:0]  cpu_bus_mask_w,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_data_w,
    output logic [3:0]  mem_mask_w,
    output logic        loading,
    output logic        error
);

    localparam int IDXW = $clog2(MAX_WORDS + 1);
    localparam logic [31:0]     MAX_N   = 32'(MAX_WORDS);
    localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);

    typedef enum logic [5:0] {
        ST_LEN   = 6'b000001,
        ST_DATA  = 6'b000010,
        ST_SUM   = 6'b000100,
        ST_CHECK = 6'b001000,
        ST_RUN   = 6'b010000,
        ST_ERROR = 6'b100000
    } state_t;

    state_t           state_r;
    logic [1:0]       byte_cnt_r;
    logic [31:0]      shift_r;
    logic [31:0]      acc_r;
    logic [IDXW-1:0]  widx_r;
    logic [IDXW-1:0]  len_r;
    logic             wr_pend_r;
    logic [29:0]      wr_addr_r;
    logic [31:0]      wr_data_r;
    logic             cpu_reset_r;
    logic             error_r;

    logic             take_s;
    logic             last_byte_s;
    logic [31:0]      word_s;

    // Handshake decode, assembled word and RAM bus ownership mux
    always_comb begin
        rx_ready    = reset & ((state_r == ST_LEN) | (state_r == ST_DATA) | (state_r == ST_SUM));
        take_s      = rx_valid & rx_ready;
        last_byte_s = (byte_cnt_r == 2'd3);
        word_s      = {rx_data, shift_r[31:8]};
        loading     = (state_r == ST_LEN) | (state_r == ST_DATA) |
                      (state_r == ST_SUM) | (state_r == ST_CHECK);
        cpu_reset   = cpu_reset_r;
        error       = error_r;
        if (state_r == ST_RUN) begin
            mem_addr   = cpu_bus_addr;
            mem_data_w = cpu_bus_data_w;
            mem_mask_w = cpu_bus_mask_w;
        end else begin
            mem_addr   = wr_addr_r;
            mem_data_w = wr_data_r;
            mem_mask_w = wr_pend_r ? 4'hF : 4'h0;
        end
    end

    // Loader state machine, byte assembly, checksum accumulation and write issue
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= ST_LEN;
            byte_cnt_r  <= 2'd0;
            shift_r     <= 32'd0;
            acc_r       <= 32'd0;
            widx_r      <= IDX_ZERO;
            len_r       <= IDX_ZERO;
            wr_pend_r   <= 1'b0;
            wr_addr_r   <= 30'd0;
            wr_data_r   <= 32'd0;
            cpu_reset_r <= 1'b1;
            error_r     <= 1'b0;
        end else if (load_req) begin
            // Any byte taken this cycle is dropped; a write already on the bus still completes.
            state_r     <= ST_LEN;
            byte_cnt_r  <= 2'd0;
            shift_r     <= 32'd0;
            acc_r       <= 32'd0;
            widx_r      <= IDX_ZERO;
            len_r       <= IDX_ZERO;
            wr_pend_r   <= 1'b0;
            cpu_reset_r <= 1'b1;
            error_r     <= 1'b0;
        end else begin
            wr_pend_r <= 1'b0;
            if (take_s) begin
                byte_cnt_r <= byte_cnt_r + 2'd1;
                shift_r    <= word_s;
            end
            case (state_r)
                ST_LEN: begin
                    if (take_s && last_byte_s) begin
                        acc_r  <= word_s;
                        len_r  <= word_s[IDXW-1:0];
                        widx_r <= IDX_ZERO;
                        if (word_s > MAX_N) begin
                            state_r <= ST_ERROR;
                            error_r <= 1'b1;
                        end else if (word_s == 32'd0) begin
                            state_r <= ST_SUM;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (take_s && last_byte_s) begin
                        wr_data_r <= word_s;
                        wr_addr_r <= BASE_WADDR + 30'(widx_r);
                        wr_pend_r <= 1'b1;
                        acc_r     <= acc_r + word_s;
                        widx_r    <= widx_r + IDX_ONE;
                        if ((widx_r + IDX_ONE) == len_r) begin
                            state_r <= ST_SUM;
                        end
                    end
                end
                ST_SUM: begin
                    if (take_s && last_byte_s) begin
                        state_r <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (shift_r == acc_r) begin
                        state_r     <= ST_RUN;
                        cpu_reset_r <= 1'b0;
                    end else begin
                        state_r <= ST_ERROR;
                        error_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                end
                ST_ERROR: begin
                    state_r <= ST_ERROR;
                end
                default: begin
                    state_r     <= ST_LEN;
                    cpu_reset_r <= 1'b1;
                    error_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule
